// File: rtl/mips_isa_pkg.sv
// MIPS32 subset decode helpers shared by the hazard controller and its scoreboard.
// Opcode classes, source/destination extraction and FSM state encoding.
package mips_isa_pkg;

    localparam logic [5:0] OP_RR_LO = 6'b000000;
    localparam logic [5:0] OP_RR_HI = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_RM_LO = 6'b001010;
    localparam logic [5:0] OP_RM_HI = 6'b001100;
    localparam logic [5:0] OP_BEQZ  = 6'b001101;
    localparam logic [5:0] OP_BNEQZ = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // Unassigned opcode: decodes as no sources, no destination.
    localparam logic [31:0] NOP_INSTR = {6'b010000, 26'd0};

    typedef enum logic [2:0] {
        CLS_NOP, CLS_RR, CLS_RM, CLS_LW, CLS_SW, CLS_BR, CLS_HLT
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_RUN, ST_DRAIN, ST_HALTED
    } state_e;

    typedef struct packed {
        logic       v;
        logic [4:0] idx;
    } dest_t;

    function automatic logic [5:0] op_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [4:0] rs_of(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[15:11];
    endfunction

    function automatic instr_class_e class_of(input logic [5:0] op);
        instr_class_e cls;
        cls = CLS_NOP;
        if (op >= OP_RR_LO && op <= OP_RR_HI)
            cls = CLS_RR;
        else if (op >= OP_RM_LO && op <= OP_RM_HI)
            cls = CLS_RM;
        else if (op == OP_LW)
            cls = CLS_LW;
        else if (op == OP_SW)
            cls = CLS_SW;
        else if (op == OP_BEQZ || op == OP_BNEQZ)
            cls = CLS_BR;
        else if (op == OP_HLT)
            cls = CLS_HLT;
        return cls;
    endfunction

    function automatic logic src_uses_rs(input instr_class_e cls);
        return cls inside {CLS_RR, CLS_RM, CLS_LW, CLS_SW, CLS_BR};
    endfunction

    // SW reads rt as the store data.
    function automatic logic src_uses_rt(input instr_class_e cls);
        return cls inside {CLS_RR, CLS_SW};
    endfunction

    // R0 is hardwired, so a write to it never creates a dependency.
    function automatic dest_t dest_of(input logic [31:0] instr);
        dest_t        d;
        instr_class_e cls;
        cls   = class_of(op_of(instr));
        d.v   = 1'b0;
        d.idx = 5'd0;
        if (cls == CLS_RR) begin
            d.v   = 1'b1;
            d.idx = rd_of(instr);
        end else if (cls == CLS_RM || cls == CLS_LW) begin
            d.v   = 1'b1;
            d.idx = rt_of(instr);
        end
        if (d.idx == 5'd0)
            d.v = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/mips_dest_scoreboard.sv
// Shift register of destinations for in-flight instructions (entry 0 = EX),
// compared against the sources of the instruction in ID.
module mips_dest_scoreboard
    import mips_isa_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  dest_t      push,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       use_rs,
    input  logic       use_rt,
    output logic       hit
);

    dest_t [DEPTH-1:0] ent;

    always_ff @(posedge clock) begin
        if (reset) begin
            ent <= '0;
        end else begin
            ent[0] <= push;
            for (int i = 1; i < DEPTH; i++)
                ent[i] <= ent[i-1];
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].v && ent[i].idx != 5'd0) begin
                if (use_rs && ent[i].idx == rs)
                    hit = 1'b1;
                if (use_rt && ent[i].idx == rt)
                    hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Issue/interlock controller for the 5-stage pipeline: RAW stalls, branch
// squash, and the HLT drain sequence, all decided in the same cycle.
module mips_hazard_ctrl
    import mips_isa_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             branch_taken,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             fetch_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    // Without WB->ID bypass the producer must clear WB before ID may read.
    localparam int DEPTH = WB_BYPASS ? 2 : 3;
    localparam int DW    = $clog2(DEPTH + 1);

    state_e        state, state_nx;
    logic [DW-1:0] drain_cnt, drain_cnt_nx;

    instr_class_e cls;
    dest_t        id_dest;
    dest_t        push;
    logic         hit;
    logic         hazard;
    logic         issue;

    assign cls     = class_of(op_of(id_instr));
    assign id_dest = dest_of(id_instr);

    mips_dest_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .clock  (clock),
        .reset  (reset),
        .push   (push),
        .rs     (rs_of(id_instr)),
        .rt     (rt_of(id_instr)),
        .use_rs (src_uses_rs(cls)),
        .use_rt (src_uses_rt(cls)),
        .hit    (hit)
    );

    assign hazard    = id_valid & hit;
    assign issue     = id_valid & ~hazard & ~branch_taken & (state == ST_RUN);
    assign push.v    = issue & id_dest.v;
    assign push.idx  = id_dest.idx;

    assign stall_if  = hazard & ~branch_taken;
    assign bubble_ex = ~issue;
    assign flush_id  = branch_taken;
    assign fetch_en  = (state == ST_RUN) & ~stall_if;
    assign halted    = (state == ST_HALTED);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_cnt_nx;
        end
    end

    // DRAIN lasts DEPTH+1 cycles so halted rises DEPTH+2 cycles after HLT issue.
    always_comb begin
        state_nx     = state;
        drain_cnt_nx = drain_cnt;
        case (state)
            ST_RUN: begin
                drain_cnt_nx = '0;
                if (issue && cls == CLS_HLT)
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt == DW'(DEPTH))
                    state_nx = ST_HALTED;
                else
                    drain_cnt_nx = drain_cnt + DW'(1);
            end
            ST_HALTED: state_nx = ST_HALTED;
            default:   state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            stall_count <= '0;
        else if (stall_if && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench: drives one stream into WB_BYPASS=1 and WB_BYPASS=0 instances
// and checks stall/issue/halt timing against hand-computed values.
module tb_mips_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        branch_taken;

    logic        stall_if1, bubble_ex1, flush_id1, fetch_en1, halted1;
    logic [15:0] stall_count1;
    logic        stall_if0, bubble_ex0, flush_id0, fetch_en0, halted0;
    logic [15:0] stall_count0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mips_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(16)) dut1 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .branch_taken(branch_taken), .stall_if(stall_if1), .bubble_ex(bubble_ex1),
        .flush_id(flush_id1), .fetch_en(fetch_en1), .halted(halted1),
        .stall_count(stall_count1)
    );

    mips_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(16)) dut0 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .branch_taken(branch_taken), .stall_if(stall_if0), .bubble_ex(bubble_ex0),
        .flush_id(flush_id0), .fetch_en(fetch_en0), .halted(halted0),
        .stall_count(stall_count0)
    );

    function automatic logic [31:0] rr(input logic [4:0] rd, rs, rt);
        return {6'd0, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] im(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Drive one ID cycle just after the edge; outputs are checked 1 ns later.
    task automatic step(input logic v, input logic [31:0] instr, input logic bt);
        cyc();
        id_valid     = v;
        id_instr     = instr;
        branch_taken = bt;
        #1;
    endtask

    task automatic do_reset(input string tag);
        cyc();
        reset        = 1'b1;
        id_valid     = 1'b0;
        id_instr     = '0;
        branch_taken = 1'b0;
        cyc();
        reset = 1'b0;
        #1;
        chk({tag, "_stall1"},  stall_if1,    0);
        chk({tag, "_bubble1"}, bubble_ex1,   1);
        chk({tag, "_flush1"},  flush_id1,    0);
        chk({tag, "_fetch1"},  fetch_en1,    1);
        chk({tag, "_halt1"},   halted1,      0);
        chk({tag, "_cnt1"},    stall_count1, 0);
        chk({tag, "_stall0"},  stall_if0,    0);
        chk({tag, "_bubble0"}, bubble_ex0,   1);
        chk({tag, "_fetch0"},  fetch_en0,    1);
        chk({tag, "_halt0"},   halted0,      0);
        chk({tag, "_cnt0"},    stall_count0, 0);
    endtask

    // Producer then dependent consumer held in ID: 2 stalls at depth 2, 3 at depth 3.
    task automatic raw_pair(input string tag, input logic [31:0] p, input logic [31:0] c);
        step(1, p, 0);
        chk({tag, "_p_issue1"}, bubble_ex1, 0);
        step(1, c, 0);
        chk({tag, "_c1_st1"}, stall_if1, 1);
        chk({tag, "_c1_st0"}, stall_if0, 1);
        chk({tag, "_c1_fe1"}, fetch_en1, 0);
        step(1, c, 0);
        chk({tag, "_c2_st1"}, stall_if1, 1);
        chk({tag, "_c2_st0"}, stall_if0, 1);
        step(1, c, 0);
        chk({tag, "_c3_st1"}, stall_if1, 0);
        chk({tag, "_c3_bub1"}, bubble_ex1, 0);
        chk({tag, "_c3_st0"}, stall_if0, 1);
        step(1, c, 0);
        chk({tag, "_c4_st0"}, stall_if0, 0);
        chk({tag, "_c4_bub0"}, bubble_ex0, 0);
        chk({tag, "_cnt1"}, stall_count1, 2);
        chk({tag, "_cnt0"}, stall_count0, 3);
    endtask

    initial begin
        reset        = 1'b1;
        id_valid     = 1'b0;
        id_instr     = '0;
        branch_taken = 1'b0;
        cyc();

        // Reset state, then RT-destination and RD-destination RAW pairs
        do_reset("rst0");
        raw_pair("t1", im(6'd10, 5'd0, 5'd1, 16'd10), rr(5'd4, 5'd1, 5'd2));
        do_reset("rst1");
        raw_pair("t2", rr(5'd4, 5'd1, 5'd2), rr(5'd5, 5'd4, 5'd3));

        // R0 never hits; SW rt is a source; BR after SW sees no destination
        do_reset("rst2");
        step(1, im(6'd10, 5'd0, 5'd0, 16'd5), 0);
        chk("t3_addi_r0_issue", bubble_ex1, 0);
        step(1, rr(5'd6, 5'd0, 5'd0), 0);
        chk("t3_r0_st1", stall_if1, 0);
        chk("t3_r0_st0", stall_if0, 0);
        chk("t3_r0_bub1", bubble_ex1, 0);
        step(1, im(6'd10, 5'd0, 5'd1, 16'd10), 0);
        step(1, im(6'd9, 5'd2, 5'd1, 16'd0), 0);
        chk("t3_sw_st1", stall_if1, 1);
        chk("t3_sw_st0", stall_if0, 1);
        step(1, im(6'd9, 5'd2, 5'd1, 16'd0), 0);
        chk("t3_sw2_st1", stall_if1, 1);
        step(1, im(6'd9, 5'd2, 5'd1, 16'd0), 0);
        chk("t3_sw3_st1", stall_if1, 0);
        chk("t3_sw3_st0", stall_if0, 1);
        step(1, im(6'd13, 5'd5, 5'd0, 16'd4), 0);
        chk("t3_br_st1", stall_if1, 0);
        chk("t3_br_st0", stall_if0, 0);
        chk("t3_br_bub1", bubble_ex1, 0);

        // Branch squash wins over hazard; older entry R1 keeps shifting
        do_reset("rst3");
        step(1, im(6'd10, 5'd0, 5'd1, 16'd10), 0);
        step(1, rr(5'd4, 5'd1, 5'd2), 1);
        chk("t4_flush1", flush_id1, 1);
        chk("t4_st1", stall_if1, 0);
        chk("t4_bub1", bubble_ex1, 1);
        chk("t4_st0", stall_if0, 0);
        chk("t4_fe1", fetch_en1, 1);
        step(1, rr(5'd7, 5'd4, 5'd0), 0);
        chk("t4_r4_st1", stall_if1, 0);
        chk("t4_r4_st0", stall_if0, 0);
        chk("t4_noflush1", flush_id1, 0);
        step(1, rr(5'd8, 5'd1, 5'd0), 0);
        chk("t4_r1_st1", stall_if1, 0);
        chk("t4_r1_st0", stall_if0, 1);
        chk("t4_cnt1", stall_count1, 0);

        // HLT drain: halted at HLT issue + DEPTH + 2
        do_reset("rst4");
        step(1, im(6'd10, 5'd0, 5'd1, 16'd1), 0);
        step(1, im(6'd10, 5'd0, 5'd2, 16'd2), 0);
        step(1, {6'd63, 26'd0}, 0);
        chk("t5_hlt_bub1", bubble_ex1, 0);
        chk("t5_hlt_fe1", fetch_en1, 1);
        step(1, im(6'd10, 5'd0, 5'd3, 16'd1), 0);
        chk("t5_d1_fe1", fetch_en1, 0);
        chk("t5_d1_fe0", fetch_en0, 0);
        chk("t5_d1_bub1", bubble_ex1, 1);
        chk("t5_d1_h1", halted1, 0);
        step(1, im(6'd10, 5'd0, 5'd3, 16'd1), 0);
        chk("t5_d2_h1", halted1, 0);
        step(1, im(6'd10, 5'd0, 5'd3, 16'd1), 0);
        chk("t5_d3_h1", halted1, 0);
        chk("t5_d3_h0", halted0, 0);
        step(1, im(6'd10, 5'd0, 5'd3, 16'd1), 0);
        chk("t5_d4_h1", halted1, 1);
        chk("t5_d4_h0", halted0, 0);
        step(1, im(6'd10, 5'd0, 5'd3, 16'd1), 0);
        chk("t5_d5_h1", halted1, 1);
        chk("t5_d5_h0", halted0, 1);
        step(1, im(6'd10, 5'd0, 5'd3, 16'd1), 1);
        chk("t5_d6_h1", halted1, 1);
        chk("t5_d6_fe1", fetch_en1, 0);
        chk("t5_d6_bub1", bubble_ex1, 1);

        // Reset mid-stall, then a RAW pair behaves normally
        do_reset("rst5");
        step(1, im(6'd10, 5'd0, 5'd1, 16'd10), 0);
        step(1, rr(5'd4, 5'd1, 5'd2), 0);
        chk("t6_pre_st1", stall_if1, 1);
        do_reset("t6_midstall");
        raw_pair("t6a", im(6'd10, 5'd0, 5'd1, 16'd10), rr(5'd4, 5'd1, 5'd2));

        // Reset in DRAIN
        do_reset("rst6");
        step(1, {6'd63, 26'd0}, 0);
        step(1, im(6'd10, 5'd0, 5'd3, 16'd1), 0);
        chk("t6_drain_fe1", fetch_en1, 0);
        do_reset("t6_drain");
        raw_pair("t6b", im(6'd10, 5'd0, 5'd1, 16'd10), rr(5'd4, 5'd1, 5'd2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
